logic_sched: RTL and testbench

LOGIC_SCHED -- requirements
Module: logic_sched

---
 rtl/logic_sched.sv | 146 ++++++++++++++
 tb/tb_logic_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_sched.sv
// logic_sched: two-requester scheduler in front of a shared 8-bit logic unit.
// Single ops (AND/OR/NOT/NAND) take one EXEC cycle. XOR is built as
// (a|b) & ~(a&b) over three passes, P1..P3. Arbitration is round-robin or
// fixed priority (requester 0 wins), selected by RR_EN.
module logic_sched #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] res,
  output logic       err,
  output logic       busy,
  output logic [7:0] count,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_ctrl,
  input  logic [7:0] alu_s
);

  typedef enum logic [2:0] {IDLE, EXEC, P1, P2, P3, DONE} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } oper_t;

  state_t     state, state_nx;
  oper_t      [1:0] in_req;
  oper_t      cur;
  logic [1:0] req_v;
  logic [1:0] gnt_q;
  logic [7:0] t1, t2;
  logic       pick, owner, last, err_q, accept, illegal;

  assign req_v     = {req1, req0};
  assign in_req[0] = {op0, a0, b0};
  assign in_req[1] = {op1, a1, b1};
  assign accept    = (state == IDLE) && (req_v != 2'b00);
  // 101..111 are illegal; 100 is the XOR macro
  assign illegal   = cur.op[2] && (cur.op[1:0] != 2'b00);
  assign gnt0      = gnt_q[0];
  assign gnt1      = gnt_q[1];

  // Winner select: a lone requester wins; a tie goes to the one not served last
  // (round-robin) or to requester 0 (fixed priority).
  always_comb begin
    pick = req_v[1] & ~req_v[0];
    if (req_v == 2'b11) pick = RR_EN ? ~last : 1'b0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (in_req[pick].op == 3'b100) ? P1 : EXEC;
      EXEC:    state_nx = DONE;
      P1:      state_nx = P2;
      P2:      state_nx = P3;
      P3:      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: logic-unit drive, status and completion pulses
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = 2'b00;
    done0    = 1'b0;
    done1    = 1'b0;
    err      = 1'b0;
    busy     = (state != IDLE);
    case (state)
      EXEC: if (!illegal) begin
        alu_a    = cur.a;
        alu_b    = cur.b;
        alu_ctrl = cur.op[1:0];
      end
      P1: begin alu_a = cur.a; alu_b = cur.b; alu_ctrl = 2'b01; end
      P2: begin alu_a = cur.a; alu_b = cur.b; alu_ctrl = 2'b11; end
      P3: begin alu_a = t1;    alu_b = t2;    alu_ctrl = 2'b00; end
      DONE: begin
        done0 = ~owner;
        done1 = owner;
        err   = err_q;
      end
      default: ;
    endcase
  end

  // Datapath: operand latch, grant pulse, partial results, result and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= '0;
      owner <= 1'b0;
      last  <= 1'b1;   // so requester 0 takes the first tie
      err_q <= 1'b0;
      gnt_q <= 2'b00;
      res   <= '0;
      t1    <= '0;
      t2    <= '0;
      count <= '0;
    end else begin
      gnt_q <= 2'b00;
      if (accept) begin
        cur   <= in_req[pick];
        owner <= pick;
        last  <= pick;
        err_q <= 1'b0;
        gnt_q <= pick ? 2'b10 : 2'b01;
      end
      case (state)
        EXEC: begin
          res   <= illegal ? 8'h00 : alu_s;
          err_q <= illegal;
        end
        P1:      t1    <= alu_s;
        P2:      t2    <= alu_s;
        P3:      res   <= alu_s;
        DONE:    count <= count + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_sched.sv
// Bench for logic_sched: one round-robin and one fixed-priority instance,
// each fed by a behavioural logic unit, checked against an opcode-level model.
module tb_logic_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0, req1, fr0, fr1;
  logic [2:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;

  logic       r_gnt0, r_gnt1, r_done0, r_done1, r_err, r_busy;
  logic [7:0] r_res, r_count, r_alu_a, r_alu_b, r_alu_s;
  logic [1:0] r_alu_ctrl;
  logic       f_gnt0, f_gnt1, f_done0, f_done1, f_err, f_busy;
  logic [7:0] f_res, f_count, f_alu_a, f_alu_b, f_alu_s;
  logic [1:0] f_alu_ctrl;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  // The external shared logic unit
  function automatic logic [7:0] alu_f(input logic [1:0] c, input logic [7:0] x, input logic [7:0] y);
    case (c)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return ~x;
      default: return ~(x & y);
    endcase
  endfunction

  assign r_alu_s = alu_f(r_alu_ctrl, r_alu_a, r_alu_b);
  assign f_alu_s = alu_f(f_alu_ctrl, f_alu_a, f_alu_b);

  // Reference: {err, res} for an opcode
  function automatic logic [8:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, ~a};
      3'd3:    return {1'b0, ~(a & b)};
      3'd4:    return {1'b0, a ^ b};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op);
    return (op == 3'd4) ? 4 : 2;
  endfunction

  logic_sched #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(r_gnt0), .gnt1(r_gnt1),
    .done0(r_done0), .done1(r_done1), .res(r_res), .err(r_err), .busy(r_busy),
    .count(r_count), .alu_a(r_alu_a), .alu_b(r_alu_b), .alu_ctrl(r_alu_ctrl),
    .alu_s(r_alu_s));

  logic_sched #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req0(fr0), .req1(fr1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(f_gnt0), .gnt1(f_gnt1),
    .done0(f_done0), .done1(f_done1), .res(f_res), .err(f_err), .busy(f_busy),
    .count(f_count), .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_ctrl(f_alu_ctrl),
    .alu_s(f_alu_s));

  // Cycle invariants: one-hot gnt/done, err only alongside done
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((r_gnt0 & r_gnt1) | (r_done0 & r_done1) | (r_err & ~(r_done0 | r_done1)) |
          (f_gnt0 & f_gnt1) | (f_done0 & f_done1) | (f_err & ~(f_done0 | f_done1))) begin
        errors++;
        $display("FAIL invariant @%0t: rr gnt=%b%b done=%b%b err=%b fp gnt=%b%b done=%b%b err=%b, want one-hot and err only with done",
                 $time, r_gnt1, r_gnt0, r_done1, r_done0, r_err, f_gnt1, f_gnt0, f_done1, f_done0, f_err);
      end
    end
  end

  // Runs one request on the round-robin instance and records what it saw.
  // gk/dk are cycles after acceptance edge (-1 = never seen).
  task automatic do_op(input bit r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int gk, output int dk, output logic [7:0] rs, output logic er,
                       output logic [2:0][1:0] cs, output logic [7:0] c0, output bit xbad);
    gk = -1; dk = -1; rs = 8'h00; er = 1'b0; cs = '0; xbad = 1'b0;
    @(negedge clk);
    c0 = r_count;
    if (!r) begin op0 = op; a0 = a; b0 = b; req0 = 1'b1; end
    else    begin op1 = op; a1 = a; b1 = b; req1 = 1'b1; end
    for (int k = 1; k <= 12 && dk < 0; k++) begin
      @(negedge clk);
      if (k <= 3) cs[k-1] = r_alu_ctrl;
      if (r ? r_gnt1 : r_gnt0) begin gk = k; req0 = 1'b0; req1 = 1'b0; end
      if ((r ? r_gnt0 : r_gnt1) || (r ? r_done0 : r_done1)) xbad = 1'b1;
      if (r ? r_done1 : r_done0) begin dk = k; rs = r_res; er = r_err; end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r_gnt0, r_gnt1, r_done0, r_done1, r_err, r_busy, r_res, r_count, r_alu_a, r_alu_b, r_alu_ctrl} !== '0) begin
      errors++;
      $display("FAIL reset_rr: got gnt=%b%b done=%b%b err=%b busy=%b res=%h cnt=%h alu=%h/%h/%b want all 0",
               r_gnt1, r_gnt0, r_done1, r_done0, r_err, r_busy, r_res, r_count, r_alu_a, r_alu_b, r_alu_ctrl);
    end
    checks++;
    if ({f_gnt0, f_gnt1, f_done0, f_done1, f_err, f_busy, f_res, f_count, f_alu_a, f_alu_b, f_alu_ctrl} !== '0) begin
      errors++;
      $display("FAIL reset_fp: got busy=%b res=%h cnt=%h alu_ctrl=%b want all 0", f_busy, f_res, f_count, f_alu_ctrl);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_ops();
    logic [2:0] ops [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [7:0] want [4] = '{8'h30, 8'hFC, 8'h0F, 8'hCF};
    int gk, dk; logic [7:0] rs, c0; logic er; logic [2:0][1:0] cs; bit xb;
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, ops[i], 8'hF0, 8'h3C, gk, dk, rs, er, cs, c0, xb);
      checks++;
      if (gk !== 1 || dk !== 2 || xb) begin
        errors++;
        $display("FAIL ops_timing op=%0d: got gnt@%0d done@%0d cross=%0b want gnt@1 done@2 cross=0", ops[i], gk, dk, xb);
      end
      checks++;
      if (rs !== want[i] || er !== 1'b0) begin
        errors++;
        $display("FAIL ops_result op=%0d: got res=%h err=%b want res=%h err=0", ops[i], rs, er, want[i]);
      end
      checks++;
      if (cs[0] !== ops[i][1:0] || c0 !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL ops_ctrl op=%0d: got ctrl=%b cnt=%h want ctrl=%b cnt=%h", ops[i], cs[0], c0, ops[i][1:0], 8'(exp_cnt));
      end
      exp_cnt++;
    end
  endtask

  task automatic test_xor();
    int gk, dk; logic [7:0] rs, c0; logic er; logic [2:0][1:0] cs; bit xb;
    do_op(1'b1, 3'd4, 8'hF0, 8'h3C, gk, dk, rs, er, cs, c0, xb);
    exp_cnt++;
    checks++;
    if (gk !== 1 || dk !== 4 || xb) begin
      errors++;
      $display("FAIL xor_timing: got gnt1@%0d done1@%0d cross=%0b want gnt1@1 done1@4 cross=0", gk, dk, xb);
    end
    checks++;
    if (cs[0] !== 2'b01 || cs[1] !== 2'b11 || cs[2] !== 2'b00) begin
      errors++;
      $display("FAIL xor_ctrl: got %b,%b,%b want 01,11,00", cs[0], cs[1], cs[2]);
    end
    checks++;
    if (rs !== 8'hCC || er !== 1'b0) begin
      errors++;
      $display("FAIL xor_result: got res=%h err=%b want res=cc err=0", rs, er);
    end
  endtask

  task automatic test_illegal();
    int gk, dk; logic [7:0] rs, c0; logic er; logic [2:0][1:0] cs; bit xb;
    do_op(1'b0, 3'd6, 8'hA5, 8'h5A, gk, dk, rs, er, cs, c0, xb);
    exp_cnt++;
    checks++;
    if (dk !== 2 || rs !== 8'h00 || er !== 1'b1 || cs[0] !== 2'b00) begin
      errors++;
      $display("FAIL illegal: got done@%0d res=%h err=%b ctrl=%b want done@2 res=00 err=1 ctrl=00", dk, rs, er, cs[0]);
    end
    do_op(1'b0, 3'd1, 8'h12, 8'h40, gk, dk, rs, er, cs, c0, xb);
    exp_cnt++;
    checks++;
    if (dk !== 2 || rs !== 8'h52 || er !== 1'b0) begin
      errors++;
      $display("FAIL illegal_recover: got done@%0d res=%h err=%b want done@2 res=52 err=0", dk, rs, er);
    end
  endtask

  task automatic test_rr();
    int ng, nd; logic g; logic [8:0] e;
    ng = 0; nd = 0; g = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; exp_cnt = 0;
    @(negedge clk);
    op0 = 3'($urandom_range(0, 3)); a0 = 8'($urandom); b0 = 8'($urandom);
    op1 = 3'($urandom_range(0, 4)); a1 = 8'($urandom); b1 = 8'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 60 && nd < 4; c++) begin
      @(negedge clk);
      if (r_gnt0 | r_gnt1) begin
        checks++;
        if (r_gnt1 !== 1'(ng % 2)) begin
          errors++;
          $display("FAIL rr_order grant#%0d: got gnt1=%b want gnt1=%0d", ng, r_gnt1, ng % 2);
        end
        g = r_gnt1; ng++;
      end
      if (r_done0 | r_done1) begin
        e = g ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
        checks++;
        if (r_done1 !== g || r_res !== e[7:0] || r_count !== 8'(nd)) begin
          errors++;
          $display("FAIL rr_done#%0d: got done1=%b res=%h cnt=%h want done1=%b res=%h cnt=%h",
                   nd, r_done1, r_res, r_count, g, e[7:0], 8'(nd));
        end
        nd++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (nd !== 4) begin
      errors++;
      $display("FAIL rr_timeout: got %0d dones want 4", nd);
    end
    @(negedge clk);
    checks++;
    if (r_count !== 8'd4) begin
      errors++;
      $display("FAIL rr_count: got %h want 04", r_count);
    end
    exp_cnt = 4;
  endtask

  task automatic test_fixed();
    int g0, g1;
    g0 = 0; g1 = 0;
    op0 = 3'd0; op1 = 3'd1;
    fr0 = 1'b1; fr1 = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (f_gnt0) g0++;
      if (f_gnt1) g1++;
    end
    fr0 = 1'b0; fr1 = 1'b0;
    checks++;
    if (g0 !== 10 || g1 !== 0) begin
      errors++;
      $display("FAIL fixed_prio: got gnt0 x%0d gnt1 x%0d want gnt0 x10 gnt1 x0", g0, g1);
    end
    checks++;
    if (f_count !== 8'd10) begin
      errors++;
      $display("FAIL fixed_count: got %h want 0a", f_count);
    end
  endtask

  task automatic test_random();
    int gk, dk; logic [7:0] rs, c0, a, b; logic er; logic [2:0][1:0] cs; bit xb, r;
    logic [2:0] op; logic [8:0] e;
    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom); op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
      do_op(r, op, a, b, gk, dk, rs, er, cs, c0, xb);
      e = ref_op(op, a, b);
      checks++;
      if (gk !== 1 || dk !== ref_lat(op) || xb || c0 !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL rand#%0d req%0d op=%0d: got gnt@%0d done@%0d cross=%0b cnt=%h want gnt@1 done@%0d cross=0 cnt=%h",
                 i, r, op, gk, dk, xb, c0, ref_lat(op), 8'(exp_cnt));
      end
      checks++;
      if (rs !== e[7:0] || er !== e[8]) begin
        errors++;
        $display("FAIL rand_result#%0d op=%0d a=%h b=%h: got res=%h err=%b want res=%h err=%b", i, op, a, b, rs, er, e[7:0], e[8]);
      end
      exp_cnt = (exp_cnt + 1) % 256;
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    op1 = 3'd4; a1 = 8'h0F; b1 = 8'hFF; req1 = 1'b1;
    @(negedge clk);            // P1, gnt1
    req1 = 1'b0;
    @(negedge clk);            // P2
    checks++;
    if (r_busy !== 1'b1 || r_alu_ctrl !== 2'b11) begin
      errors++;
      $display("FAIL midrst_pre: got busy=%b ctrl=%b want busy=1 ctrl=11", r_busy, r_alu_ctrl);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r_busy, r_done0, r_done1, r_err, r_gnt0, r_gnt1, r_res, r_count, r_alu_a, r_alu_b, r_alu_ctrl} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got busy=%b done=%b%b res=%h cnt=%h alu=%h/%h/%b want all 0",
               r_busy, r_done1, r_done0, r_res, r_count, r_alu_a, r_alu_b, r_alu_ctrl);
    end
    @(negedge clk);
    rst_n = 1'b1; exp_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (r_done0 | r_done1 | r_busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midrst_nodone: got activity after reset want none");
    end
    // first edge after release with a request must accept it
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; op0 = 3'd0; a0 = 8'hFF; b0 = 8'h81; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    checks++;
    if (r_gnt0 !== 1'b1 || r_busy !== 1'b1) begin
      errors++;
      $display("FAIL first_accept: got gnt0=%b busy=%b want gnt0=1 busy=1", r_gnt0, r_busy);
    end
    @(negedge clk);
    checks++;
    if (r_done0 !== 1'b1 || r_res !== 8'h81) begin
      errors++;
      $display("FAIL first_accept_done: got done0=%b res=%h want done0=1 res=81", r_done0, r_res);
    end
  endtask

  task automatic test_wrap();
    int gk, dk; logic [7:0] rs, c0; logic er; logic [2:0][1:0] cs; bit xb;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      do_op(1'($urandom), 3'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), gk, dk, rs, er, cs, c0, xb);
      if (i == 0 || i == 255) begin
        checks++;
        if (c0 !== 8'(i)) begin
          errors++;
          $display("FAIL wrap_progress op#%0d: got cnt=%h want %h", i, c0, 8'(i));
        end
      end
    end
    @(negedge clk);
    checks++;
    if (r_count !== 8'h00) begin
      errors++;
      $display("FAIL wrap_count: got %h want 00", r_count);
    end
  endtask

  initial begin
    req0 = 1'b0; req1 = 1'b0; fr0 = 1'b0; fr1 = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_ops();
    test_xor();
    test_illegal();
    test_rr();
    test_fixed();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
